// File: rtl/console_pkg.sv
// Shared types and constants for the text console: FSM states, control codes,
// the blank cell value and the 16-entry CGA palette.
package console_pkg;

    typedef enum logic [1:0] {
        CLEAR_ALL = 2'd0,
        IDLE      = 2'd1,
        CLEAR_ROW = 2'd2
    } state_t;

    localparam logic [7:0] CC_CR = 8'h0D;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;

    // {attr, char}: light grey on black, space
    localparam logic [15:0] BLANK_CELL = 16'h0720;

    localparam logic [23:0] PALETTE [16] = '{
        24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
        24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
        24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
        24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
    };

endpackage

// File: rtl/text_console_font_rom.sv
// 256 x 16 x 8 glyph ROM with a registered output (1-cycle latency). The table is a
// compact case ROM so it needs no external init file: space/NUL blank, 'A' drawn, others a box.
module font_rom (
    input  logic       clk_pixel,
    input  logic [7:0] char_code,
    input  logic [3:0] glyph_y,
    output logic [7:0] row_bits
);

    logic [7:0] rom_row;

    always_comb begin
        rom_row = 8'h00;
        case (char_code)
            8'h00, 8'h20: rom_row = 8'h00;
            8'h41: begin
                case (glyph_y)
                    4'd2:                              rom_row = 8'h18;
                    4'd3:                              rom_row = 8'h3C;
                    4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10: rom_row = 8'h66;
                    4'd6:                              rom_row = 8'h7E;
                    default:                           rom_row = 8'h00;
                endcase
            end
            default: begin
                if (glyph_y == 4'd2 || glyph_y == 4'd13)
                    rom_row = 8'h7E;
                else if (glyph_y > 4'd2 && glyph_y < 4'd13)
                    rom_row = 8'h42;
                else
                    rom_row = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        row_bits <= rom_row;
    end

endmodule

// File: rtl/text_console.sv
// Character-cell text renderer feeding the hdmi block: 80x30 cell buffer, byte-stream write port,
// scrolling via circular row offset. Define TEXT_CONSOLE_CURSOR_BLINK_EN for a blinking underline cursor.
module text_console import console_pkg::*; #(
    parameter int COLS     = 80,
    parameter int ROWS     = 30,
    parameter int CHAR_W   = 8,
    parameter int CHAR_H   = 16,
    parameter int CX_WIDTH = 10
) (
    input  logic                clk_pixel,
    input  logic                reset,
    input  logic [CX_WIDTH-1:0] cx,
    input  logic [CX_WIDTH-1:0] cy,
    output logic [23:0]         rgb,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [7:0]          wr_char,
    input  logic [7:0]          wr_attr,
    output logic [6:0]          cursor_col,
    output logic [4:0]          cursor_row,
    output logic [1:0]          fsm_state
);

    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);
    localparam int GX_W  = $clog2(CHAR_W);
    localparam int GY_W  = $clog2(CHAR_H);

    // Write handshake: a byte is consumed on a clock edge where wr_valid && wr_ready;
    // wr_ready is high only in IDLE and does not depend on wr_valid.

    function automatic logic [4:0] wrap_row(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'(ROWS))
            s = s - 6'(ROWS);
        return s[4:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
        return AW'(row) * AW'(COLS) + AW'(col);
    endfunction

    state_t         state, state_n;
    logic [AW-1:0]  clr_cnt, clr_n;
    logic [6:0]     col_n;
    logic [4:0]     row_n;
    logic [4:0]     top, top_n, top_disp;
    logic           newline;
    logic           buf_we;
    logic [AW-1:0]  buf_waddr;
    logic [15:0]    buf_wdata;

    assign fsm_state = state;

    always_comb begin
        state_n   = state;
        clr_n     = clr_cnt;
        col_n     = cursor_col;
        row_n     = cursor_row;
        top_n     = top;
        newline   = 1'b0;
        buf_we    = 1'b0;
        buf_waddr = '0;
        buf_wdata = BLANK_CELL;
        wr_ready  = 1'b0;
        case (state)
            CLEAR_ALL: begin
                buf_we    = 1'b1;
                buf_waddr = clr_cnt;
                clr_n     = clr_cnt + AW'(1);
                if (clr_cnt == AW'(CELLS - 1)) begin
                    state_n = IDLE;
                    clr_n   = '0;
                    top_n   = '0;
                    col_n   = '0;
                    row_n   = '0;
                end
            end
            IDLE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    case (wr_char)
                        CC_CR: col_n = '0;
                        CC_LF: begin
                            col_n   = '0;
                            newline = 1'b1;
                        end
                        CC_FF: begin
                            state_n = CLEAR_ALL;
                            clr_n   = '0;
                        end
                        default: begin
                            buf_we    = 1'b1;
                            buf_waddr = cell_addr(wrap_row(cursor_row, top), cursor_col);
                            buf_wdata = {wr_attr, wr_char};
                            if (cursor_col == 7'(COLS - 1)) begin
                                col_n   = '0;
                                newline = 1'b1;
                            end else begin
                                col_n = cursor_col + 7'd1;
                            end
                        end
                    endcase
                    if (newline) begin
                        if (cursor_row < 5'(ROWS - 1)) begin
                            row_n = cursor_row + 5'd1;
                        end else begin
                            // Scroll: the old top row becomes the new bottom and is blanked
                            top_n   = wrap_row(top, 5'd1);
                            state_n = CLEAR_ROW;
                            clr_n   = '0;
                        end
                    end
                end
            end
            CLEAR_ROW: begin
                buf_we    = 1'b1;
                buf_waddr = cell_addr(wrap_row(5'(ROWS - 1), top), 7'(clr_cnt));
                clr_n     = clr_cnt + AW'(1);
                if (clr_cnt == AW'(COLS - 1)) begin
                    state_n = IDLE;
                    clr_n   = '0;
                end
            end
            default: begin
                state_n = CLEAR_ALL;
                clr_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state      <= CLEAR_ALL;
            clr_cnt    <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
            top        <= '0;
            top_disp   <= '0;
        end else begin
            state      <= state_n;
            clr_cnt    <= clr_n;
            cursor_col <= col_n;
            cursor_row <= row_n;
            top        <= top_n;
            // Latch the scroll offset only at frame start so a frame never tears
            if (cx == '0 && cy == '0)
                top_disp <= top;
        end
    end

    // Read pipeline S0: cell coordinates and buffer address
    logic [6:0]      s0_col;
    logic [4:0]      s0_row;
    logic            s0_active;
    logic            s0_cursor;
    logic [AW-1:0]   rd_addr;

    assign s0_col    = 7'(cx / CX_WIDTH'(CHAR_W));
    assign s0_row    = 5'(cy / CX_WIDTH'(CHAR_H));
    assign s0_active = (cx < CX_WIDTH'(COLS * CHAR_W)) && (cy < CX_WIDTH'(ROWS * CHAR_H));
    assign rd_addr   = s0_active ? cell_addr(wrap_row(s0_row, top_disp), s0_col) : '0;

`ifdef TEXT_CONSOLE_CURSOR_BLINK_EN
    logic [5:0] frame_cnt;

    always_ff @(posedge clk_pixel) begin
        if (reset)
            frame_cnt <= '0;
        else if (cx == '0 && cy == '0)
            frame_cnt <= frame_cnt + 6'd1;
    end

    assign s0_cursor = frame_cnt[5] && (state == IDLE) && (s0_row == cursor_row) &&
                       (s0_col == cursor_col) && (cy[GY_W-1:0] >= GY_W'(CHAR_H - 2));
`else
    assign s0_cursor = 1'b0;
`endif

    logic [15:0] mem [0:CELLS-1];
    logic [15:0] rd_data;

    // Simple dual-port buffer; a same-address read returns the old contents
    always_ff @(posedge clk_pixel) begin
        if (buf_we)
            mem[buf_waddr] <= buf_wdata;
        rd_data <= mem[rd_addr];
    end

    logic [GY_W-1:0] s1_gy;
    logic [GX_W-1:0] s1_gx, s2_gx;
    logic            s1_active, s2_active, s1_cursor, s2_cursor;
    logic [7:0]      s2_attr;
    logic [7:0]      font_bits;

    font_rom u_font_rom (
        .clk_pixel (clk_pixel),
        .char_code (rd_data[7:0]),
        .glyph_y   (s1_gy),
        .row_bits  (font_bits)
    );

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            s1_gy     <= '0;
            s1_gx     <= '0;
            s1_active <= 1'b0;
            s1_cursor <= 1'b0;
            s2_gx     <= '0;
            s2_active <= 1'b0;
            s2_cursor <= 1'b0;
            s2_attr   <= '0;
            rgb       <= '0;
        end else begin
            s1_gy     <= cy[GY_W-1:0];
            s1_gx     <= cx[GX_W-1:0];
            s1_active <= s0_active;
            s1_cursor <= s0_cursor;
            s2_gx     <= s1_gx;
            s2_active <= s1_active;
            s2_cursor <= s1_cursor;
            s2_attr   <= rd_data[15:8];
            if (!s2_active)
                rgb <= '0;
            else if (s2_cursor || font_bits[GX_W'(CHAR_W - 1) - s2_gx])
                rgb <= PALETTE[s2_attr[3:0]];
            else
                rgb <= PALETTE[s2_attr[7:4]];
        end
    end

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: reset clear, glyph rendering, wrap/CR, scrolling,
// inactive area and clear/reset restart.
module tb_text_console;

    logic        clk_pixel = 1'b0;
    logic        reset;
    logic [9:0]  cx, cy;
    logic [23:0] rgb;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_char, wr_attr;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_pass   = 0;

    text_console dut (
        .clk_pixel  (clk_pixel),
        .reset      (reset),
        .cx         (cx),
        .cy         (cy),
        .rgb        (rgb),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_char    (wr_char),
        .wr_attr    (wr_attr),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .fsm_state  (fsm_state)
    );

    // clock / reset
    always #5 clk_pixel = ~clk_pixel;

    // driver tasks (all start and end on a falling edge)
    task automatic send(input logic [7:0] c, input logic [7:0] a);
        int t = 0;
        while (wr_ready !== 1'b1 && t < 5000) begin
            @(negedge clk_pixel);
            t++;
        end
        if (t >= 5000) begin
            n_checks++;
            $display("FAIL send_timeout char=%h wr_ready never rose", c);
        end
        wr_valid = 1'b1;
        wr_char  = c;
        wr_attr  = a;
        @(negedge clk_pixel);
        wr_valid = 1'b0;
    endtask

    task automatic get_pixel(input int x, input int y, output logic [23:0] v);
        cx = 10'(x);
        cy = 10'(y);
        repeat (3) @(negedge clk_pixel);
        v  = rgb;
        cx = 10'd700;
        cy = 10'd500;
    endtask

    task automatic frame_start();
        cx = 10'd0;
        cy = 10'd0;
        @(negedge clk_pixel);
        cx = 10'd700;
        cy = 10'd500;
        @(negedge clk_pixel);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (wr_ready === 1'b0 && n < 3000) begin
            n++;
            @(negedge clk_pixel);
        end
    endtask

    task automatic test_reset();
        int n;
        logic [23:0] v;
        reset = 1'b1;
        @(negedge clk_pixel);
        n_checks++;
        if (wr_ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", wr_ready); else n_pass++;
        n_checks++;
        if (rgb !== 24'h0) $display("FAIL reset_rgb got %h exp 000000", rgb); else n_pass++;
        reset = 1'b0;
        count_busy(n);
        n_checks++;
        if (n !== 2400) $display("FAIL reset_clear_len got %0d exp 2400", n); else n_pass++;
        n_checks++;
        if (cursor_col !== 7'd0 || cursor_row !== 5'd0)
            $display("FAIL reset_cursor got %0d/%0d exp 0/0", cursor_col, cursor_row);
        else n_pass++;
        get_pixel(5, 5, v);
        n_checks++;
        if (v !== 24'h000000) $display("FAIL reset_pixel got %h exp 000000", v); else n_pass++;
    endtask

    task automatic test_char_a();
        logic [23:0] v;
        send(8'h41, 8'h1F);
        n_checks++;
        if (cursor_col !== 7'd1) $display("FAIL a_cursor_col got %0d exp 1", cursor_col); else n_pass++;
        get_pixel(2, 3, v);
        n_checks++;
        if (v !== 24'hFFFFFF) $display("FAIL a_fg_row3 got %h exp FFFFFF", v); else n_pass++;
        get_pixel(0, 3, v);
        n_checks++;
        if (v !== 24'h0000AA) $display("FAIL a_bg_row3 got %h exp 0000AA", v); else n_pass++;
        get_pixel(6, 3, v);
        n_checks++;
        if (v !== 24'h0000AA) $display("FAIL a_bg_row3_x6 got %h exp 0000AA", v); else n_pass++;
        get_pixel(1, 6, v);
        n_checks++;
        if (v !== 24'hFFFFFF) $display("FAIL a_fg_row6 got %h exp FFFFFF", v); else n_pass++;
        get_pixel(3, 0, v);
        n_checks++;
        if (v !== 24'h0000AA) $display("FAIL a_bg_row0 got %h exp 0000AA", v); else n_pass++;
        get_pixel(10, 3, v);
        n_checks++;
        if (v !== 24'h000000) $display("FAIL a_next_cell got %h exp 000000", v); else n_pass++;
    endtask

    task automatic test_latency();
        cx = 10'd700; cy = 10'd500;
        repeat (3) @(negedge clk_pixel);
        cx = 10'd2; cy = 10'd3;
        @(negedge clk_pixel);
        cx = 10'd0; cy = 10'd3;
        @(negedge clk_pixel);
        cx = 10'd700; cy = 10'd500;
        n_checks++;
        if (rgb !== 24'h000000) $display("FAIL lat_early got %h exp 000000", rgb); else n_pass++;
        @(negedge clk_pixel);
        n_checks++;
        if (rgb !== 24'hFFFFFF) $display("FAIL lat_first got %h exp FFFFFF", rgb); else n_pass++;
        @(negedge clk_pixel);
        n_checks++;
        if (rgb !== 24'h0000AA) $display("FAIL lat_second got %h exp 0000AA", rgb); else n_pass++;
        @(negedge clk_pixel);
        n_checks++;
        if (rgb !== 24'h000000) $display("FAIL lat_third got %h exp 000000", rgb); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [23:0] v;
        send(8'h0D, 8'h00);
        n_checks++;
        if (cursor_col !== 7'd0 || cursor_row !== 5'd0)
            $display("FAIL cr_row0 got %0d/%0d exp 0/0", cursor_col, cursor_row);
        else n_pass++;
        for (int i = 0; i < 79; i++) send(8'h20, 8'h2E);
        n_checks++;
        if (cursor_col !== 7'd79 || cursor_row !== 5'd0)
            $display("FAIL wrap_col79 got %0d/%0d exp 79/0", cursor_col, cursor_row);
        else n_pass++;
        send(8'h41, 8'h4E);
        n_checks++;
        if (cursor_col !== 7'd0 || cursor_row !== 5'd1)
            $display("FAIL wrap_next got %0d/%0d exp 0/1", cursor_col, cursor_row);
        else n_pass++;
        for (int i = 0; i < 3; i++) send(8'h41, 8'h1F);
        send(8'h0D, 8'h00);
        n_checks++;
        if (cursor_col !== 7'd0 || cursor_row !== 5'd1)
            $display("FAIL cr_row1 got %0d/%0d exp 0/1", cursor_col, cursor_row);
        else n_pass++;
        get_pixel(322, 3, v);
        n_checks++;
        if (v !== 24'h00AA00) $display("FAIL wrap_space_bg got %h exp 00AA00", v); else n_pass++;
        get_pixel(634, 3, v);
        n_checks++;
        if (v !== 24'hFFFF55) $display("FAIL wrap_last_fg got %h exp FFFF55", v); else n_pass++;
        get_pixel(632, 3, v);
        n_checks++;
        if (v !== 24'hAA0000) $display("FAIL wrap_last_bg got %h exp AA0000", v); else n_pass++;
        get_pixel(2, 19, v);
        n_checks++;
        if (v !== 24'hFFFFFF) $display("FAIL row1_fg got %h exp FFFFFF", v); else n_pass++;
    endtask

    task automatic test_scroll();
        int n;
        logic [23:0] v;
        for (int i = 0; i < 28; i++) send(8'h0A, 8'h00);
        n_checks++;
        if (cursor_row !== 5'd29 || wr_ready !== 1'b1)
            $display("FAIL lf_to_bottom got row %0d ready %b exp 29 1", cursor_row, wr_ready);
        else n_pass++;
        send(8'h0A, 8'h00);
        n_checks++;
        if (fsm_state !== 2'd2) $display("FAIL scroll_state got %0d exp 2", fsm_state); else n_pass++;
        count_busy(n);
        n_checks++;
        if (n !== 80) $display("FAIL scroll_busy_len got %0d exp 80", n); else n_pass++;
        n_checks++;
        if (cursor_row !== 5'd29 || cursor_col !== 7'd0)
            $display("FAIL scroll_cursor got %0d/%0d exp 0/29", cursor_col, cursor_row);
        else n_pass++;
        get_pixel(2, 19, v);
        n_checks++;
        if (v !== 24'hFFFFFF) $display("FAIL scroll_no_tear got %h exp FFFFFF", v); else n_pass++;
        frame_start();
        get_pixel(2, 3, v);
        n_checks++;
        if (v !== 24'hFFFFFF) $display("FAIL scroll_top_row got %h exp FFFFFF", v); else n_pass++;
        get_pixel(2, 19, v);
        n_checks++;
        if (v !== 24'h000000) $display("FAIL scroll_row1 got %h exp 000000", v); else n_pass++;
        get_pixel(2, 467, v);
        n_checks++;
        if (v !== 24'h000000) $display("FAIL scroll_bottom_blank got %h exp 000000", v); else n_pass++;
        send(8'h41, 8'h1F);
        get_pixel(2, 467, v);
        n_checks++;
        if (v !== 24'hFFFFFF) $display("FAIL scroll_bottom_write got %h exp FFFFFF", v); else n_pass++;
    endtask

    task automatic test_inactive();
        logic [23:0] v;
        get_pixel(640, 100, v);
        n_checks++;
        if (v !== 24'h000000) $display("FAIL inactive_x got %h exp 000000", v); else n_pass++;
        get_pixel(10, 480, v);
        n_checks++;
        if (v !== 24'h000000) $display("FAIL inactive_y got %h exp 000000", v); else n_pass++;
        get_pixel(10, 483, v);
        n_checks++;
        if (v !== 24'h000000) $display("FAIL inactive_y3 got %h exp 000000", v); else n_pass++;
    endtask

    task automatic test_clear_and_reset();
        int n;
        logic [23:0] v;
        send(8'h0C, 8'h00);
        count_busy(n);
        n_checks++;
        if (n !== 2400) $display("FAIL ff_clear_len got %0d exp 2400", n); else n_pass++;
        n_checks++;
        if (cursor_col !== 7'd0 || cursor_row !== 5'd0)
            $display("FAIL ff_cursor got %0d/%0d exp 0/0", cursor_col, cursor_row);
        else n_pass++;
        frame_start();
        get_pixel(2, 3, v);
        n_checks++;
        if (v !== 24'h000000) $display("FAIL ff_blank got %h exp 000000", v); else n_pass++;
        send(8'h41, 8'h1F);
        get_pixel(2, 3, v);
        n_checks++;
        if (v !== 24'hFFFFFF) $display("FAIL ff_rewrite got %h exp FFFFFF", v); else n_pass++;
        send(8'h0C, 8'h00);
        repeat (1200) @(negedge clk_pixel);
        n_checks++;
        if (fsm_state !== 2'd0) $display("FAIL mid_clear_state got %0d exp 0", fsm_state); else n_pass++;
        reset = 1'b1;
        @(negedge clk_pixel);
        reset = 1'b0;
        count_busy(n);
        n_checks++;
        if (n !== 2400) $display("FAIL reset_restart_len got %0d exp 2400", n); else n_pass++;
        n_checks++;
        if (cursor_col !== 7'd0 || cursor_row !== 5'd0)
            $display("FAIL reset_restart_cursor got %0d/%0d exp 0/0", cursor_col, cursor_row);
        else n_pass++;
        get_pixel(2, 3, v);
        n_checks++;
        if (v !== 24'h000000) $display("FAIL reset_restart_pixel got %h exp 000000", v); else n_pass++;
    endtask

    initial begin
        reset    = 1'b1;
        cx       = 10'd700;
        cy       = 10'd500;
        wr_valid = 1'b0;
        wr_char  = 8'h00;
        wr_attr  = 8'h00;
        repeat (2) @(negedge clk_pixel);
        test_reset();
        test_char_a();
        test_latency();
        test_wrap();
        test_scroll();
        test_inactive();
        test_clear_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
